spi_master: RTL and testbench



---
 rtl/spi_master_pkg.sv | 20 ++
 rtl/spi_clkgen.sv | 33 +++
 rtl/spi_master.sv | 128 ++++++++++++
 tb/tb_spi_master.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_master_pkg.sv
// Shared SPI frame definitions: R/W encoding, field widths and FSM state encodings.
// The memory slave's own state defines import these too, so both ends agree on the frame.
package spi_master_pkg;

  localparam logic RW_READ    = 1'b1;
  localparam logic RW_WRITE   = 1'b0;
  localparam int   ADDR_BITS  = 7;
  localparam int   DATA_BITS  = 8;
  localparam int   FRAME_BITS = ADDR_BITS + 1 + DATA_BITS;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CS_SETUP = 3'd1,
    SCLK_LO  = 3'd2,
    SCLK_HI  = 3'd3,
    CS_HOLD  = 3'd4,
    CS_GAP   = 3'd5
  } state_t;

endpackage

// File: rtl/spi_clkgen.sv
// Half-period timer for the SPI master: emits phase_end on the last clk cycle of each
// sclk half-period and owns the sclk register, which toggles when the FSM asks.
module spi_clkgen #(
  parameter int HALF_PERIOD = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic toggle,
  output logic phase_end,
  output logic sclk
);

  localparam int CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(HALF_PERIOD - 1);

  logic [CW-1:0] cnt;

  assign phase_end = en && (cnt == LAST);

  // Disabled means idle: counter parked at 0 so the first phase of a frame is a full one.
  always_ff @(posedge clk) begin
    if (reset || !en) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else begin
      if (phase_end) cnt <= '0;
      else           cnt <= cnt + 1'b1;
      if (toggle) sclk <= ~sclk;
    end
  end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master: sends {addr[6:0], rw, data[7:0]} MSB first and returns read data.
// Define SPI_MASTER_MISO_SYNC_EN to pass miso_pin through a 2-flop synchroniser.
module spi_master
  import spi_master_pkg::*;
#(
  parameter int HALF_PERIOD = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       sclk_pin,
  output logic       cs_pin,
  output logic       mosi_pin,
  input  logic       miso_pin,
  output logic [2:0] state_dbg
);

  state_t                  state;
  logic [FRAME_BITS-1:0]   tx_sr;
  logic [DATA_BITS-1:0]    rx_sr;
  logic [3:0]              bit_cnt;
  logic                    rw_q;
  logic                    hold_half;
  logic                    phase_end;
  logic                    toggle;
  logic                    en;
  logic                    miso_s;

`ifdef SPI_MASTER_MISO_SYNC_EN
  logic [1:0] miso_sync;
  always_ff @(posedge clk) begin
    if (reset) miso_sync <= 2'b00;
    else       miso_sync <= {miso_sync[0], miso_pin};
  end
  assign miso_s = miso_sync[1];
`else
  assign miso_s = miso_pin;
`endif

  assign en        = (state != IDLE);
  assign toggle    = phase_end && (state == CS_SETUP || state == SCLK_LO || state == SCLK_HI);
  assign state_dbg = state;

  spi_clkgen #(.HALF_PERIOD(HALF_PERIOD)) u_clkgen (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .toggle    (toggle),
    .phase_end (phase_end),
    .sclk      (sclk_pin)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cs_pin    <= 1'b1;
      mosi_pin  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rdata     <= 8'h00;
      tx_sr     <= '0;
      rx_sr     <= '0;
      bit_cnt   <= 4'd0;
      rw_q      <= 1'b0;
      hold_half <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // Read frames send zeros in the data slot.
            tx_sr    <= {addr, rw, (rw == RW_READ) ? 8'h00 : wdata};
            rw_q     <= rw;
            cs_pin   <= 1'b0;
            busy     <= 1'b1;
            mosi_pin <= addr[6];
            bit_cnt  <= 4'd0;
            state    <= CS_SETUP;
          end
        end
        CS_SETUP: if (phase_end) state <= SCLK_HI;
        SCLK_HI: begin
          if (phase_end) begin
            if (rw_q && bit_cnt >= 4'd8) rx_sr <= {rx_sr[6:0], miso_s};
            if (bit_cnt == 4'd15) begin
              hold_half <= 1'b0;
              state     <= CS_HOLD;
            end else begin
              bit_cnt  <= bit_cnt + 4'd1;
              mosi_pin <= tx_sr[FRAME_BITS-2];
              tx_sr    <= {tx_sr[FRAME_BITS-2:0], 1'b0};
              state    <= SCLK_LO;
            end
          end
        end
        SCLK_LO: if (phase_end) state <= SCLK_HI;
        CS_HOLD: begin
          // sclk stays low for a full sclk period after the last rise before CS releases.
          if (phase_end) begin
            if (!hold_half) begin
              hold_half <= 1'b1;
            end else begin
              cs_pin   <= 1'b1;
              done     <= 1'b1;
              mosi_pin <= 1'b0;
              if (rw_q) rdata <= rx_sr;
              state    <= CS_GAP;
            end
          end
        end
        CS_GAP: begin
          if (phase_end) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: behavioural SPI memory slave, frame driver and a queue-based
// scoreboard monitor checking done timing, mosi bits, rdata and busy release.
module tb_spi_master;

  localparam int H = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic [6:0] addr = 7'h00;
  logic [7:0] wdata = 8'h00;
  logic       busy, done, sclk_pin, cs_pin, mosi_pin;
  logic [7:0] rdata;
  logic       miso_pin;
  logic [2:0] state_dbg;

  spi_master #(.HALF_PERIOD(H)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .rw        (rw),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .rdata     (rdata),
    .sclk_pin  (sclk_pin),
    .cs_pin    (cs_pin),
    .mosi_pin  (mosi_pin),
    .miso_pin  (miso_pin),
    .state_dbg (state_dbg)
  );

  // Clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] exp_done_q[$];
  logic [31:0] exp_end_q[$];
  logic [15:0] exp_mosi_q[$];
  logic [7:0]  exp_rdata_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural SPI memory slave, mode 0
  logic [7:0] mem[128];
  int         s_cnt;
  logic [15:0] s_sh;
  logic [6:0] s_addr;
  logic       s_rw;
  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    mem[5] = 8'h5A;
    miso_pin = 1'bx;
  end

  always @(posedge sclk_pin or negedge cs_pin) begin
    if (!sclk_pin) begin
      s_cnt = 0;
      s_sh  = 16'h0;
    end else if (!cs_pin) begin
      s_sh  = {s_sh[14:0], mosi_pin};
      s_cnt = s_cnt + 1;
      if (s_cnt == 8) begin
        s_addr = s_sh[7:1];
        s_rw   = s_sh[0];
      end
      if (s_cnt == 16 && !s_rw) mem[s_addr] = s_sh[7:0];
    end
  end

  always @(negedge sclk_pin or posedge cs_pin) begin
    if (cs_pin) begin
      miso_pin = 1'bx;
    end else if (s_rw && s_cnt >= 8 && s_cnt < 16) begin
      logic [7:0] d;
      d = mem[s_addr];
      miso_pin = d[15 - s_cnt];
    end else begin
      miso_pin = 1'bx;
    end
  end

  // mosi capture at each sclk rise, cleared when a frame opens
  logic [4:0]  rise_cnt = 5'd0;
  logic [15:0] mon_bits = 16'h0;
  always @(posedge sclk_pin or negedge cs_pin) begin
    if (!sclk_pin) begin
      rise_cnt = 5'd0;
      mon_bits = 16'h0;
    end else begin
      rise_cnt = rise_cnt + 5'd1;
      mon_bits = {mon_bits[14:0], mosi_pin};
    end
  end

  // Scoreboard monitor
  logic prev_busy = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      prev_busy = 1'b0;
    end else begin
      if (done) begin
        check("done_while_busy", {31'd0, busy}, 32'd1);
        if (exp_done_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
        end else begin
          check("done_cycle", cyc, exp_done_q.pop_front());
          check("mosi_frame", {11'd0, rise_cnt, mon_bits}, {11'd0, 5'd16, exp_mosi_q.pop_front()});
          check("rdata", {24'd0, rdata}, {24'd0, exp_rdata_q.pop_front()});
        end
      end
      if (prev_busy && !busy) begin
        if (exp_end_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_busy_end: got busy drop at cycle %0d expected none", cyc);
        end else begin
          check("busy_end_cycle", cyc, exp_end_q.pop_front());
        end
      end
      prev_busy = busy;
    end
  end

  // Driver tasks
  task automatic issue(input logic rw_i, input logic [6:0] a, input logic [7:0] d,
                       input logic [7:0] exp_rd);
    int t_acc;
    start = 1'b1;
    rw    = rw_i;
    addr  = a;
    wdata = d;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    t_acc = cyc;
    check("accept_cs_busy", {30'd0, cs_pin, busy}, 32'd1);
    exp_done_q.push_back(t_acc + 34 * H);
    exp_end_q.push_back(t_acc + 35 * H);
    exp_mosi_q.push_back({a, rw_i, rw_i ? 8'h00 : d});
    exp_rdata_q.push_back(exp_rd);
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 40 * H; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    if (busy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL busy_timeout: got busy=1 after %0d cycles expected 0", 40 * H);
    end
    @(negedge clk);
  endtask

  initial begin
    logic gap_ok;
    int   k;

    // Reset held three cycles
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_cs",    {31'd0, cs_pin},   32'd1);
    check("reset_sclk",  {31'd0, sclk_pin}, 32'd0);
    check("reset_mosi",  {31'd0, mosi_pin}, 32'd0);
    check("reset_busy",  {31'd0, busy},     32'd0);
    check("reset_done",  {31'd0, done},     32'd0);
    check("reset_rdata", {24'd0, rdata},    32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Write 0xC3 to 0x2A, then read preloaded 0x5A from 0x05
    issue(1'b0, 7'h2A, 8'hC3, 8'h00);
    wait_idle();
    issue(1'b1, 7'h05, 8'hFF, 8'h5A);
    wait_idle();

    // Busy rejection: starts mid-frame and in the done cycle
    issue(1'b0, 7'h01, 8'h7F, 8'h5A);
    repeat (100) @(negedge clk);
    start = 1'b1; rw = 1'b1; addr = 7'h33; wdata = 8'h11;
    @(negedge clk);
    start = 1'b0;
    for (k = 0; k < 40 * H; k++) begin
      if (done) break;
      @(negedge clk);
    end
    check("done_seen", {31'd0, done}, 32'd1);
    start = 1'b1; rw = 1'b0; addr = 7'h44; wdata = 8'h22;
    @(negedge clk);
    start = 1'b0;
    gap_ok = cs_pin;
    for (int i = 0; i < H - 1; i++) begin
      @(negedge clk);
      gap_ok = gap_ok & cs_pin;
    end
    check("gap_cs_high", {31'd0, gap_ok}, 32'd1);
    wait_idle();
    repeat (2 * H) @(negedge clk);
    check("no_second_frame", {30'd0, busy, cs_pin}, 32'd1);

    // Read back what was written
    issue(1'b1, 7'h01, 8'h00, 8'h7F);
    wait_idle();

    // Reset after the 5th sclk rise aborts the frame
    issue(1'b0, 7'h10, 8'hAA, 8'h00);
    for (k = 0; k < 20 * H; k++) begin
      if (rise_cnt == 5'd5) break;
      @(negedge clk);
    end
    check("fifth_rise_seen", {27'd0, rise_cnt}, 32'd5);
    reset = 1'b1;
    exp_done_q.delete();
    exp_end_q.delete();
    exp_mosi_q.delete();
    exp_rdata_q.delete();
    @(negedge clk);
    check("abort_cs_sclk_done", {29'd0, cs_pin, sclk_pin, done}, 32'd4);
    check("abort_rdata", {24'd0, rdata}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Frames after the abort are clean
    issue(1'b0, 7'h22, 8'h96, 8'h00);
    wait_idle();
    issue(1'b1, 7'h22, 8'h00, 8'h96);
    wait_idle();
    repeat (4) @(negedge clk);

    if (exp_done_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL missing_done: got %0d outstanding frames expected 0", exp_done_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
